// File: rtl/instr_fetch.sv
// Instruction fetch/decode stage feeding controlPulses: fetches a word at pc,
// holds its decode for the whole execute phase and carries the EXTEND flag forward.
module instr_fetch #(
    parameter int              WORD_W   = 15,
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = 12'o4000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    output logic              mem_rd,
    output logic [PC_W-1:0]   mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_valid,
    input  logic              exec_done,
    input  logic              ext_flag,
    input  logic              branch_en,
    input  logic [PC_W-1:0]   branch_addr,
    output logic [2:0]        opcode,
    output logic [1:0]        qc,
    output logic [PC_W-1:0]   operand,
    output logic              extracode,
    output logic              instr_valid,
    output logic [PC_W-1:0]   pc
);

    typedef enum logic {FETCH, EXEC} state_t;

    state_t            state, state_next;
    logic [WORD_W-1:0] ir;
    logic              ext_seen;
    logic              fetch_fire;
    logic              done_fire;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        fetch_fire = 1'b0;
        done_fire  = 1'b0;
        case (state)
            FETCH: begin
                // Request is masked during reset so an in-flight word is never taken.
                mem_rd = !hold && !reset;
                if (mem_rd && mem_valid) begin
                    fetch_fire = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    done_fire  = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            ir        <= '0;
            extracode <= 1'b0;
            ext_seen  <= 1'b0;
        end else if (fetch_fire) begin
            ir <= mem_rdata;
            pc <= pc + PC_W'(1);
        end else if (done_fire) begin
            // extracode marks only the instruction that follows an EXTEND.
            extracode <= ext_seen || ext_flag;
            ext_seen  <= 1'b0;
            if (branch_en) pc <= branch_addr;
        end else if (state == EXEC && ext_flag) begin
            ext_seen <= 1'b1;
        end
    end

    assign mem_addr    = pc;
    assign instr_valid = (state == EXEC);
    assign opcode      = ir[14:12];
    assign qc          = ir[11:10];
    assign operand     = ir[PC_W-1:0];

endmodule
